bus_arbiter_n: RTL and testbench
================================

// Module: bus_arbiter_n
// PURPOSE
//   Parametrised N-master arbiter for the shared system bus (VGA fetch, UART master, CPU, DMA ...).
//   Selects one requesting master, registers its grant and muxes its addr/data/we/cs onto the bus.
//   Routes the slave ack back to the granted master only, and aborts hung cycles with a timeout error.
//   Bus read data (i_dat) is broadcast to all masters outside this block.
//   Supports fixed-priority and round-robin modes, plus locked (multi-ack) tenures.
// PARAMETERS
//   NUM_MASTERS  3   number of masters (2..8); index 0 = highest fixed priority
//   AW           16  address width
//   DW           8   data width
//   MODE         0   0 = fixed priority (lowest index wins), 1 = round robin
//   TIMEOUT      255 cycles in BUSY without ack before abort; 0 = timeout disabled
// PORTS
//   i_clk      in   1               system clock
//   i_reset    in   1               asynchronous, active-low reset
//   i_m_cs     in   NUM_MASTERS     per-master request / chip select
//   i_m_we     in   NUM_MASTERS     per-master write enable
//   i_m_lock   in   NUM_MASTERS     keep grant across acks while high
//   i_m_addr   in   NUM_MASTERS*AW  per-master address, master k at [k*AW +: AW]
//   i_m_dat    in   NUM_MASTERS*DW  per-master write data, master k at [k*DW +: DW]
//   o_m_grant  out  NUM_MASTERS     registered one-hot grant
//   o_m_ack    out  NUM_MASTERS     ack routed to the granted master
//   o_m_err    out  NUM_MASTERS     one-cycle timeout-abort pulse
//   o_addr     out  AW              bus address
//   o_dat      out  DW              bus write data
//   o_we       out  1               bus write enable
//   o_cs       out  1               bus chip select
//   i_ack      in   1               slave acknowledge
// BEHAVIOUR
//   Reset (i_reset=0, async)
//     - State IDLE; o_m_grant=0, o_m_err=0; RR pointer=NUM_MASTERS-1; timeout counter=0.
//     - Bus outputs therefore 0. A reset mid-transaction drops the grant immediately.
//   FSM: IDLE -> BUSY -> IDLE
//     - IDLE: if any i_m_cs, then on the next edge grant the winner (one-hot) and go to BUSY.
//       Latency: request at cycle n -> grant and bus driven at cycle n+1.
//     - BUSY: grant is held. Leave for IDLE on the edge where one of these holds:
//       (a) granted cs low (master withdrew; no ack/err);
//       (b) i_ack=1 and granted lock=0 (normal completion);
//       (c) counter == TIMEOUT-1 without ack and TIMEOUT!=0 (abort).
//     - Abort: o_m_err[g] pulses for exactly 1 cycle, registered alongside the grant drop.
//     - i_ack with lock=1: stay in BUSY and restart the counter (burst).
//     - Every release spends 1 IDLE cycle before the next grant; no back-to-back grants.
//   Winner selection
//     - MODE 0: lowest index with cs=1.
//     - MODE 1: first cs=1 scanning ptr+1, ptr+2 ... modulo NUM_MASTERS.
//       ptr updates to the granted index on every grant. Wrap-around from NUM_MASTERS-1 to 0.
//   Bus mux (combinational from registered grant)
//     - o_addr/o_dat/o_we = granted master's signals; o_cs = BUSY & granted i_m_cs.
//     - All 0 when nothing is granted.
//   Ack routing
//     - o_m_ack[k] = i_ack & o_m_grant[k] & BUSY (combinational, same cycle as i_ack).
//     - i_ack seen in IDLE is ignored.
//   Timeout counter
//     - Counts BUSY cycles since the grant or the last ack; saturates; width = clog2(TIMEOUT+1).
//   Simultaneous events
//     - ack and timeout on the same edge: ack wins, no error.
//     - cs drop and ack on the same edge: ack is delivered and the tenure ends.
// TESTING
//   MODE0, masters 0 and 2 request at cycle 0 -> grant=3'b001 at cycle 1; master 2 granted 2 cycles after ack.
//   MODE1, all 3 request continuously, slave acks 1 cycle after cs -> grant order 0,1,2,0,1.
//   Lock: m1 lock=1 for 3 acks -> grant stays 3'b010 for all 3; released only after ack with lock=0.
//   TIMEOUT=4, no ack -> o_m_err pulses 1 cycle at cycle 5, grant drops, next requester wins.
//   Reset low mid-BUSY (addr 0x1234 driven) -> o_m_grant=0 and o_addr=0 immediately, without waiting for a clock.
//   Granted master drops cs before ack -> no ack/err; IDLE next cycle; stray i_ack in IDLE gives o_m_ack=0.

Source files
------------

// File: rtl/bus_arbiter_n.sv
// N-master shared-bus arbiter: fixed-priority or round-robin selection, registered one-hot grant,
// bus mux, ack routing to the granted master, locked bursts and hung-cycle timeout abort.
module bus_arbiter_n #(
    parameter int NUM_MASTERS = 3,
    parameter int AW          = 16,
    parameter int DW          = 8,
    parameter int MODE        = 0,
    parameter int TIMEOUT     = 255
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic [NUM_MASTERS-1:0]      i_m_cs,
    input  logic [NUM_MASTERS-1:0]      i_m_we,
    input  logic [NUM_MASTERS-1:0]      i_m_lock,
    input  logic [NUM_MASTERS*AW-1:0]   i_m_addr,
    input  logic [NUM_MASTERS*DW-1:0]   i_m_dat,
    output logic [NUM_MASTERS-1:0]      o_m_grant,
    output logic [NUM_MASTERS-1:0]      o_m_ack,
    output logic [NUM_MASTERS-1:0]      o_m_err,
    output logic [AW-1:0]               o_addr,
    output logic [DW-1:0]               o_dat,
    output logic                        o_we,
    output logic                        o_cs,
    input  logic                        i_ack
);

    localparam int IW = $clog2(NUM_MASTERS);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state;
    logic [NUM_MASTERS-1:0] grant;
    logic [NUM_MASTERS-1:0] err;
    logic [IW-1:0]          rr_ptr;
    logic [CW-1:0]          cnt;
    logic [IW-1:0]          win_idx;
    logic [IW-1:0]          scan_idx;
    logic                   win_found;
    int                     scan;
    logic                   busy;
    logic                   g_cs;
    logic                   g_lock;
    logic                   timeout_hit;

    assign busy        = (state == BUSY);
    assign g_cs        = |(grant & i_m_cs);
    assign g_lock      = |(grant & i_m_lock);
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        win_idx   = '0;
        win_found = 1'b0;
        scan      = 0;
        scan_idx  = '0;
        if (MODE == 0) begin
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                if (i_m_cs[i]) begin
                    win_idx   = IW'(i);
                    win_found = 1'b1;
                end
            end
        end else begin
            // Scan starts just after the last granted master and wraps around.
            for (int i = 1; i <= NUM_MASTERS; i++) begin
                scan = int'(rr_ptr) + i;
                if (scan >= NUM_MASTERS) scan = scan - NUM_MASTERS;
                scan_idx = IW'(scan);
                if (!win_found && i_m_cs[scan_idx]) begin
                    win_idx   = scan_idx;
                    win_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_addr = '0;
        o_dat  = '0;
        o_we   = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant[i]) begin
                o_addr = i_m_addr[i*AW +: AW];
                o_dat  = i_m_dat[i*DW +: DW];
                o_we   = i_m_we[i];
            end
        end
    end

    assign o_cs      = busy & g_cs;
    assign o_m_ack   = grant & {NUM_MASTERS{i_ack & busy}};
    assign o_m_grant = grant;
    assign o_m_err   = err;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state  <= IDLE;
            grant  <= '0;
            err    <= '0;
            rr_ptr <= IW'(NUM_MASTERS - 1);
            cnt    <= '0;
        end else begin
            err <= '0;
            case (state)
                IDLE: begin
                    if (|i_m_cs) begin
                        state  <= BUSY;
                        grant  <= NUM_MASTERS'(1) << win_idx;
                        rr_ptr <= win_idx;
                        cnt    <= '0;
                    end
                end
                BUSY: begin
                    // Ack outranks the timeout; a locked ack keeps the tenure alive.
                    if (i_ack && g_cs && g_lock) begin
                        cnt <= '0;
                    end else if (!g_cs || i_ack) begin
                        state <= IDLE;
                        grant <= '0;
                    end else if (timeout_hit) begin
                        state <= IDLE;
                        grant <= '0;
                        err   <= grant;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter_n.sv
// Bench for bus_arbiter_n: a fixed-priority and a round-robin instance share one stimulus,
// checked by directed scenarios and a randomized run against a tenure-level reference model.
module tb_bus_arbiter_n;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int TO = 4;
    localparam int PW = 3 * N + AW + DW + 2;

    logic            i_clk = 1'b0;
    logic            i_reset;
    logic [N-1:0]    i_m_cs;
    logic [N-1:0]    i_m_we;
    logic [N-1:0]    i_m_lock;
    logic [N*AW-1:0] i_m_addr;
    logic [N*DW-1:0] i_m_dat;
    logic            i_ack;
    logic [AW-1:0]   a_addr [N];
    logic [DW-1:0]   a_dat  [N];

    logic [N-1:0]    o_grant [2];
    logic [N-1:0]    o_ack   [2];
    logic [N-1:0]    o_err   [2];
    logic [AW-1:0]   o_addr  [2];
    logic [DW-1:0]   o_dat   [2];
    logic            o_we    [2];
    logic            o_cs    [2];

    int n_cmp = 0;
    int n_bad = 0;

    for (genvar k = 0; k < N; k++) begin : g_pack
        assign i_m_addr[k*AW +: AW] = a_addr[k];
        assign i_m_dat[k*DW +: DW]  = a_dat[k];
    end

    bus_arbiter_n #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .MODE(0), .TIMEOUT(TO)) dut_fp (
        .i_clk(i_clk), .i_reset(i_reset), .i_m_cs(i_m_cs), .i_m_we(i_m_we), .i_m_lock(i_m_lock),
        .i_m_addr(i_m_addr), .i_m_dat(i_m_dat), .o_m_grant(o_grant[0]), .o_m_ack(o_ack[0]),
        .o_m_err(o_err[0]), .o_addr(o_addr[0]), .o_dat(o_dat[0]), .o_we(o_we[0]), .o_cs(o_cs[0]),
        .i_ack(i_ack));

    bus_arbiter_n #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .MODE(1), .TIMEOUT(TO)) dut_rr (
        .i_clk(i_clk), .i_reset(i_reset), .i_m_cs(i_m_cs), .i_m_we(i_m_we), .i_m_lock(i_m_lock),
        .i_m_addr(i_m_addr), .i_m_dat(i_m_dat), .o_m_grant(o_grant[1]), .o_m_ack(o_ack[1]),
        .o_m_err(o_err[1]), .o_addr(o_addr[1]), .o_dat(o_dat[1]), .o_we(o_we[1]), .o_cs(o_cs[1]),
        .i_ack(i_ack));

    always #5 i_clk = ~i_clk;

    // Reference model, one per arbitration mode: who owns the bus, for how long, who to favour next.
    bit m_busy [2];
    int m_g    [2];
    int m_ptr  [2];
    int m_cnt  [2];
    int m_err  [2];

    function automatic bit has(logic [N-1:0] v, int k);
        return ((int'(v) >> k) & 1) == 1;
    endfunction

    function automatic int pick(int d, logic [N-1:0] cs);
        if (d == 0) begin
            for (int k = 0; k < N; k++) if (has(cs, k)) return k;
        end else begin
            for (int off = 1; off <= N; off++) if (has(cs, (m_ptr[d] + off) % N)) return (m_ptr[d] + off) % N;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (has(v, k)) return k;
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 1'b0;
            m_g[d]    = 0;
            m_ptr[d]  = N - 1;
            m_cnt[d]  = 0;
            m_err[d]  = -1;
        end
    endtask

    task automatic model_edge();
        int w;
        int g;
        for (int d = 0; d < 2; d++) begin
            m_err[d] = -1;
            if (!m_busy[d]) begin
                w = pick(d, i_m_cs);
                if (w >= 0) begin
                    m_busy[d] = 1'b1;
                    m_g[d]    = w;
                    m_ptr[d]  = w;
                    m_cnt[d]  = 0;
                end
            end else begin
                g = m_g[d];
                if (i_ack && has(i_m_cs, g) && has(i_m_lock, g)) m_cnt[d] = 0;
                else if (!has(i_m_cs, g) || i_ack) m_busy[d] = 1'b0;
                else if (m_cnt[d] + 1 == TO) begin
                    m_busy[d] = 1'b0;
                    m_err[d]  = g;
                end else m_cnt[d]++;
            end
        end
    endtask

    function automatic logic [N-1:0] e_grant(int d);
        return m_busy[d] ? (N'(1) << m_g[d]) : '0;
    endfunction

    function automatic logic [PW-1:0] e_all(int d);
        logic [N-1:0]  er;
        logic [N-1:0]  ak;
        logic [AW-1:0] ad;
        logic [DW-1:0] dt;
        er = (m_err[d] >= 0) ? (N'(1) << m_err[d]) : '0;
        ak = (m_busy[d] && i_ack) ? e_grant(d) : '0;
        ad = m_busy[d] ? a_addr[m_g[d]] : '0;
        dt = m_busy[d] ? a_dat[m_g[d]] : '0;
        return {e_grant(d), ak, er, ad, dt, m_busy[d] && has(i_m_we, m_g[d]), m_busy[d] && has(i_m_cs, m_g[d])};
    endfunction

    task automatic step();
        @(posedge i_clk);
        model_edge();
        @(negedge i_clk);
    endtask

    task automatic clear_inputs();
        i_m_cs = '0; i_m_we = '0; i_m_lock = '0; i_ack = 1'b0;
        for (int k = 0; k < N; k++) begin
            a_addr[k] = '0;
            a_dat[k]  = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_reset = 1'b0;
        clear_inputs();
        @(negedge i_clk);
        @(negedge i_clk);
        model_reset();
        i_reset = 1'b1;
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        clear_inputs();
        i_m_cs = '1; i_m_we = '1; i_ack = 1'b1;
        a_addr[0] = 16'hBEEF; a_dat[0] = 8'h5A;
        @(negedge i_clk);
        @(negedge i_clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if ({o_grant[d], o_ack[d], o_err[d], o_addr[d], o_dat[d], o_we[d], o_cs[d]} !== PW'(0)) begin
                n_bad++;
                $display("FAIL reset_outputs dut%0d: got grant=%b ack=%b err=%b addr=%h dat=%h we=%b cs=%b, want all zero",
                         d, o_grant[d], o_ack[d], o_err[d], o_addr[d], o_dat[d], o_we[d], o_cs[d]);
            end
        end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        i_m_cs = 3'b101; a_addr[0] = 16'h1111; a_addr[2] = 16'h2222;
        #1;
        n_cmp++;
        if (o_grant[0] !== 3'b000) begin n_bad++; $display("FAIL fp_no_grant_c0: got %b want 000", o_grant[0]); end
        step();
        i_ack = 1'b1;
        #1;
        n_cmp++;
        if ({o_grant[0], o_addr[0], o_cs[0], o_ack[0]} !== {3'b001, 16'h1111, 1'b1, 3'b001}) begin
            n_bad++;
            $display("FAIL fp_grant_c1: got grant=%b addr=%h cs=%b ack=%b want 001 1111 1 001", o_grant[0], o_addr[0], o_cs[0], o_ack[0]);
        end
        i_m_cs = 3'b100;
        step();
        i_ack = 1'b0;
        #1;
        n_cmp++;
        if (o_grant[0] !== 3'b000) begin n_bad++; $display("FAIL fp_idle_gap: got %b want 000", o_grant[0]); end
        step();
        #1;
        n_cmp++;
        if ({o_grant[0], o_addr[0]} !== {3'b100, 16'h2222}) begin
            n_bad++;
            $display("FAIL fp_second_grant: got grant=%b addr=%h want 100 2222", o_grant[0], o_addr[0]);
        end
        i_m_cs = '0;
        step();
        step();
    endtask

    task automatic test_round_robin();
        int order[$];
        int exp_order[5] = '{0, 1, 2, 0, 1};
        logic [N-1:0] prev_g;
        do_reset();
        i_m_cs = '1;
        prev_g = '0;
        for (int c = 0; c < 40 && order.size() < 5; c++) begin
            #1;
            if (o_grant[1] != '0 && prev_g == '0) order.push_back(onehot_idx(o_grant[1]));
            i_ack  = (o_grant[1] != '0) && (o_grant[1] == prev_g);
            prev_g = o_grant[1];
            step();
        end
        i_ack = 1'b0; i_m_cs = '0;
        n_cmp++;
        if (order.size() != 5) begin
            n_bad++;
            $display("FAIL rr_grant_count: got %0d grants want 5 within 40 cycles", order.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (order[i] != exp_order[i]) begin
                    n_bad++;
                    $display("FAIL rr_order[%0d]: got %0d want %0d", i, order[i], exp_order[i]);
                end
            end
        end
        step();
        step();
    endtask

    task automatic test_lock();
        do_reset();
        i_m_cs = 3'b010; i_m_lock = 3'b010;
        step();
        for (int a = 0; a < 3; a++) begin
            i_ack = 1'b1;
            #1;
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if ({o_grant[d], o_ack[d]} !== {3'b010, 3'b010}) begin
                    n_bad++;
                    $display("FAIL lock_ack%0d dut%0d: got grant=%b ack=%b want 010 010", a, d, o_grant[d], o_ack[d]);
                end
            end
            step();
        end
        i_ack = 1'b0; i_m_cs = 3'b011;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (o_grant[d] !== 3'b010) begin n_bad++; $display("FAIL lock_held dut%0d: got %b want 010", d, o_grant[d]); end
        end
        step();
        i_m_lock = '0; i_ack = 1'b1;
        step();
        i_ack = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (o_grant[d] !== 3'b000) begin n_bad++; $display("FAIL lock_release dut%0d: got %b want 000", d, o_grant[d]); end
        end
        step();
        #1;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (o_grant[d] !== 3'b001) begin n_bad++; $display("FAIL lock_next dut%0d: got %b want 001", d, o_grant[d]); end
        end
        i_m_cs = '0;
        step();
        step();
    endtask

    task automatic test_timeout();
        do_reset();
        i_m_cs = 3'b110;
        step();
        for (int c = 1; c <= 4; c++) begin
            #1;
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if ({o_grant[d], o_err[d]} !== {3'b010, 3'b000}) begin
                    n_bad++;
                    $display("FAIL to_wait_c%0d dut%0d: got grant=%b err=%b want 010 000", c, d, o_grant[d], o_err[d]);
                end
            end
            step();
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if ({o_grant[d], o_err[d]} !== {3'b000, 3'b010}) begin
                n_bad++;
                $display("FAIL to_abort_c5 dut%0d: got grant=%b err=%b want 000 010", d, o_grant[d], o_err[d]);
            end
        end
        i_m_cs = 3'b100;
        step();
        #1;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if ({o_grant[d], o_err[d]} !== {3'b100, 3'b000}) begin
                n_bad++;
                $display("FAIL to_next_c6 dut%0d: got grant=%b err=%b want 100 000", d, o_grant[d], o_err[d]);
            end
        end
        i_m_cs = '0;
        step();
        step();
    endtask

    task automatic test_ack_at_timeout();
        do_reset();
        i_m_cs = 3'b001;
        for (int c = 0; c < 4; c++) step();
        i_ack = 1'b1;
        #1;
        n_cmp++;
        if (o_ack[0] !== 3'b001) begin n_bad++; $display("FAIL ack_vs_to_ack: got %b want 001", o_ack[0]); end
        i_m_cs = '0;
        step();
        i_ack = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if ({o_grant[d], o_err[d]} !== {3'b000, 3'b000}) begin
                n_bad++;
                $display("FAIL ack_vs_to_noerr dut%0d: got grant=%b err=%b want 000 000", d, o_grant[d], o_err[d]);
            end
        end
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        a_addr[0] = 16'h1234; i_m_cs = 3'b001;
        step();
        #1;
        n_cmp++;
        if ({o_grant[0], o_addr[0]} !== {3'b001, 16'h1234}) begin
            n_bad++;
            $display("FAIL rstmid_pre: got grant=%b addr=%h want 001 1234", o_grant[0], o_addr[0]);
        end
        #2;
        i_reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if ({o_grant[d], o_addr[d], o_cs[d]} !== {3'b000, 16'h0000, 1'b0}) begin
                n_bad++;
                $display("FAIL rstmid_async dut%0d: got grant=%b addr=%h cs=%b want 000 0000 0", d, o_grant[d], o_addr[d], o_cs[d]);
            end
        end
        i_m_cs = '0;
    endtask

    task automatic test_withdraw();
        do_reset();
        i_m_cs = 3'b001;
        step();
        i_m_cs = '0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if ({o_ack[d], o_err[d], o_cs[d]} !== {3'b000, 3'b000, 1'b0}) begin
                n_bad++;
                $display("FAIL wd_drop dut%0d: got ack=%b err=%b cs=%b want 000 000 0", d, o_ack[d], o_err[d], o_cs[d]);
            end
        end
        step();
        i_ack = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if ({o_grant[d], o_ack[d], o_err[d]} !== {3'b000, 3'b000, 3'b000}) begin
                n_bad++;
                $display("FAIL wd_stray_ack dut%0d: got grant=%b ack=%b err=%b want 000 000 000", d, o_grant[d], o_ack[d], o_err[d]);
            end
        end
        step();
        i_ack = 1'b0;
    endtask

    task automatic test_random();
        logic [PW-1:0] obs;
        logic [PW-1:0] exp_v;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            i_m_cs   = i_m_cs ^ N'($urandom & $urandom);
            i_m_lock = N'($urandom & $urandom & $urandom);
            i_m_we   = N'($urandom);
            i_ack    = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < N; k++) begin
                a_addr[k] = AW'($urandom);
                a_dat[k]  = DW'($urandom);
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                obs   = {o_grant[d], o_ack[d], o_err[d], o_addr[d], o_dat[d], o_we[d], o_cs[d]};
                exp_v = e_all(d);
                n_cmp++;
                if (obs !== exp_v) begin
                    n_bad++;
                    $display("FAIL random[%0d] dut%0d: got %h want %h (grant,ack,err,addr,dat,we,cs)", c, d, obs, exp_v);
                end
            end
            step();
        end
        clear_inputs();
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded 100000 time units");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_lock();
        test_timeout();
        test_ack_at_timeout();
        test_reset_mid();
        test_withdraw();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
